// File: rtl/nco_sweep_mc.sv
// nco_sweep_mc: multi-channel NCO with per-channel phase offset and
// sawtooth linear frequency sweep (chirp).
//
// Each channel keeps a shadow configuration set (start, step, stop, pha).
// The config port writes the shadow set of one channel. A write with
// cfg_apply copies every shadow set to the active set on the same edge, so
// all channels retune coherently.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : advance accumulators and sweeps (0 freezes them)
//   sync_clr      : zero all phase accumulators
//   cfg_valid/cfg_ready, cfg_ch, cfg_start, cfg_step, cfg_stop, cfg_pha,
//   cfg_apply     : shadow-register write transaction with optional apply
//   sin_out/cos_out : packed signed samples, channel 0 in the LSBs
//   out_valid     : new samples this cycle (en delayed by 3)
//   sweep_wrap    : per-channel pulse on the edge a sweep reloads its start
module nco_sweep_mc #(
  parameter int CHANNELS    = 2,
  parameter int ACC_WIDTH   = 32,
  parameter int PHASE_WIDTH = 8,
  parameter int LUT_AW      = 10,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          en,
  input  logic                                          sync_clr,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [ACC_WIDTH-1:0]                          cfg_start,
  input  logic signed [ACC_WIDTH-1:0]                   cfg_step,
  input  logic [ACC_WIDTH-1:0]                          cfg_stop,
  input  logic [PHASE_WIDTH-1:0]                        cfg_pha,
  input  logic                                          cfg_apply,
  output logic [CHANNELS*DATA_WIDTH-1:0]                sin_out,
  output logic [CHANNELS*DATA_WIDTH-1:0]                cos_out,
  output logic                                          out_valid,
  output logic [CHANNELS-1:0]                           sweep_wrap
);

  localparam int LUT_N    = 1 << LUT_AW;
  localparam int PH_SHIFT = LUT_AW - PHASE_WIDTH;

  // Full-wave table entry, rounded half away from zero to the signed range.
  function automatic logic signed [DATA_WIDTH-1:0] sin_round(input int idx);
    real pi;
    real amp;
    real x;
    int  v;
    pi  = 3.14159265358979323846;
    amp = real'((1 << (DATA_WIDTH - 1)) - 1);
    x   = amp * $sin(2.0 * pi * real'(idx) / real'(LUT_N));
    if (x >= 0.0) v = $rtoi(x + 0.5);
    else          v = $rtoi(x - 0.5);
    return v[DATA_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH-1:0] lut [LUT_N];

  for (genvar i = 0; i < LUT_N; i++) begin : g_lut
    assign lut[i] = sin_round(i);
  end

  logic cfg_acc;
  logic cfg_apl;
  logic vld_p0;
  logic vld_p1;

  assign cfg_acc = cfg_valid & cfg_ready;
  assign cfg_apl = cfg_acc & cfg_apply;

  // Handshake and valid pipeline; ready drops for one cycle after an apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      cfg_ready <= ~cfg_apl;
      vld_p0    <= en;
      vld_p1    <= vld_p0;
      out_valid <= vld_p1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ACC_WIDTH-1:0]        sh_start, sh_stop, act_start, act_stop;
    logic signed [ACC_WIDTH-1:0] sh_step, act_step;
    logic [PHASE_WIDTH-1:0]      sh_pha, act_pha;
    logic [ACC_WIDTH-1:0]        nx_start, nx_stop;
    logic signed [ACC_WIDTH-1:0] nx_step;
    logic [PHASE_WIDTH-1:0]      nx_pha;
    logic [ACC_WIDTH-1:0]        fcw_cur;
    logic [ACC_WIDTH-1:0]        acc_p0;
    logic [ACC_WIDTH:0]          nxt;
    logic                        wr;
    logic                        wrap;
    logic                        wrap_q;
    logic [LUT_AW-1:0]           idx_p1;
    logic [LUT_AW-1:0]           cos_idx;
    logic signed [DATA_WIDTH-1:0] sin_p2, cos_p2;

    // Out-of-range channel numbers never match, so such writes are dropped.
    assign wr = cfg_acc && (int'(cfg_ch) == c);

    // Shadow contents including this cycle's write, so an apply that
    // carries a write picks it up on the same edge.
    assign nx_start = wr ? cfg_start : sh_start;
    assign nx_step  = wr ? cfg_step  : sh_step;
    assign nx_stop  = wr ? cfg_stop  : sh_stop;
    assign nx_pha   = wr ? cfg_pha   : sh_pha;

    // One extra bit: with a positive step it is the carry, with a negative
    // step it is set exactly when the result went below zero.
    assign nxt = {1'b0, fcw_cur} + {act_step[ACC_WIDTH-1], act_step};

    always_comb begin
      wrap = 1'b0;
      if (act_step[ACC_WIDTH-1])
        wrap = nxt[ACC_WIDTH] || (nxt[ACC_WIDTH-1:0] < act_stop);
      else if (act_step != '0)
        wrap = nxt[ACC_WIDTH] || (nxt[ACC_WIDTH-1:0] > act_stop);
    end

    assign cos_idx = idx_p1 + LUT_AW'(LUT_N / 4);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_start  <= '0;
        sh_step   <= '0;
        sh_stop   <= '0;
        sh_pha    <= '0;
        act_start <= '0;
        act_step  <= '0;
        act_stop  <= '0;
        act_pha   <= '0;
        fcw_cur   <= '0;
        wrap_q    <= 1'b0;
        acc_p0    <= '0;
        idx_p1    <= '0;
        sin_p2    <= '0;
        cos_p2    <= '0;
      end else begin
        sh_start <= nx_start;
        sh_step  <= nx_step;
        sh_stop  <= nx_stop;
        sh_pha   <= nx_pha;
        // Apply replaces the sweep update of this cycle.
        if (cfg_apl) begin
          act_start <= nx_start;
          act_step  <= nx_step;
          act_stop  <= nx_stop;
          act_pha   <= nx_pha;
          fcw_cur   <= nx_start;
        end else if (en) begin
          fcw_cur <= wrap ? act_start : nxt[ACC_WIDTH-1:0];
        end
        wrap_q <= en && !cfg_apl && wrap;
        // Stage p0: phase accumulator (adds the pre-apply tuning word).
        if (sync_clr)
          acc_p0 <= '0;
        else if (en)
          acc_p0 <= acc_p0 + fcw_cur;
        // Stage p1: table index with phase offset.
        if (vld_p0)
          idx_p1 <= acc_p0[ACC_WIDTH-1 -: LUT_AW] + (LUT_AW'(act_pha) << PH_SHIFT);
        // Stage p2: table lookup; holds while the pipeline is frozen.
        if (vld_p1) begin
          sin_p2 <= lut[idx_p1];
          cos_p2 <= lut[cos_idx];
        end
      end
    end

    assign sin_out[c*DATA_WIDTH +: DATA_WIDTH] = sin_p2;
    assign cos_out[c*DATA_WIDTH +: DATA_WIDTH] = cos_p2;
    assign sweep_wrap[c] = wrap_q;
  end

endmodule

// File: tb/tb_nco_sweep_mc.sv
// Directed bench for nco_sweep_mc. Three channels are instantiated so that
// channel number 3 is representable on cfg_ch and lies outside the range.
module tb_nco_sweep_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sync_clr = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = 2'd0;
  logic [31:0] cfg_start = 32'd0;
  logic signed [31:0] cfg_step = 32'sd0;
  logic [31:0] cfg_stop = 32'd0;
  logic [7:0]  cfg_pha = 8'd0;
  logic        cfg_apply = 1'b0;
  logic [47:0] sin_out;
  logic [47:0] cos_out;
  logic        out_valid;
  logic [2:0]  sweep_wrap;

  int errors = 0;
  int checks = 0;

  nco_sweep_mc #(
    .CHANNELS(3), .ACC_WIDTH(32), .PHASE_WIDTH(8), .LUT_AW(10), .DATA_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_stop(cfg_stop),
    .cfg_pha(cfg_pha), .cfg_apply(cfg_apply),
    .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid),
    .sweep_wrap(sweep_wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  function automatic logic [63:0] w16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return {48'd0, t};
  endfunction

  function automatic logic [63:0] s16(input int ch);
    return {48'd0, sin_out[ch*16 +: 16]};
  endfunction

  function automatic logic [63:0] c16(input int ch);
    return {48'd0, cos_out[ch*16 +: 16]};
  endfunction

  task automatic cfg(input int ch, input logic [31:0] st, input logic [31:0] sp,
                     input logic [31:0] so, input logic [7:0] ph,
                     input logic ap, input logic clr);
    int k;
    k = 0;
    while (!cfg_ready && k < 8) begin
      tick();
      k++;
    end
    if (!cfg_ready) chk("cfg_ready_timeout", 64'(cfg_ready), 64'd1);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_start = st;
    cfg_step  = sp;
    cfg_stop  = so;
    cfg_pha   = ph;
    cfg_apply = ap;
    sync_clr  = clr;
    tick();
    cfg_valid = 1'b0;
    cfg_apply = 1'b0;
    sync_clr  = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_ready", 64'(cfg_ready), 64'd0);
    chk("rst_sin", 64'(sin_out), 64'd0);
    chk("rst_cos", 64'(cos_out), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_wrap", 64'(sweep_wrap), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(cfg_ready), 64'd1);

    // Fixed tone on ch0: index advances by 4 per cycle
    cfg(0, 32'h0100_0000, 32'h0, 32'h0, 8'd0, 1'b1, 1'b0);
    chk("ready_low_after_apply", 64'(cfg_ready), 64'd0);
    en = 1'b1;
    tick();
    chk("tone_e1_valid", 64'(out_valid), 64'd0);
    chk("tone_e1_sin", s16(0), w16(0));
    tick();
    chk("tone_e2_valid", 64'(out_valid), 64'd0);
    tick();
    chk("tone_e3_valid", 64'(out_valid), 64'd1);
    chk("tone_e3_sin", s16(0), w16(804));
    chk("tone_e3_cos", c16(0), w16(32757));
    chk("idle_ch2_cos", c16(2), w16(32767));
    chk("idle_ch1_sin", s16(1), w16(0));
    tick();
    chk("tone_e4_sin", s16(0), w16(1608));
    repeat (256) tick();
    chk("tone_period", s16(0), w16(1608));

    // Phase offset 90 degrees on ch1, accumulators aligned by sync_clr
    cfg(1, 32'h0100_0000, 32'h0, 32'h0, 8'd64, 1'b1, 1'b1);
    tick();
    tick();
    chk("p64_sin0", s16(0), w16(0));
    chk("p64_cos0", c16(0), w16(32767));
    chk("p64_sin1", s16(1), w16(32767));
    tick();
    chk("p64_cos0_b", c16(0), w16(32757));
    chk("p64_sin1_b", s16(1), w16(32757));
    tick();
    chk("p64_cos0_c", c16(0), w16(32728));
    chk("p64_sin1_c", s16(1), w16(32728));

    // Phase offset 180 degrees
    cfg(1, 32'h0100_0000, 32'h0, 32'h0, 8'd128, 1'b1, 1'b1);
    tick();
    tick();
    chk("p128_sin1_a", s16(1), w16(0));
    tick();
    chk("p128_sin0_b", s16(0), w16(804));
    chk("p128_sin1_b", s16(1), w16(-804));
    tick();
    chk("p128_sin1_c", s16(1), w16(-1608));

    // Shadow writes without apply leave the active tuning untouched
    cfg(0, 32'h0200_0000, 32'h0, 32'h0, 8'd0, 1'b0, 1'b0);
    cfg(1, 32'h0200_0000, 32'h0, 32'h0, 8'd128, 1'b0, 1'b0);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    tick();
    tick();
    chk("noapply_sin0_a", s16(0), w16(0));
    tick();
    chk("noapply_sin0_b", s16(0), w16(804));
    chk("noapply_sin1_b", s16(1), w16(-804));

    // Apply carried by an out-of-range write: both channels switch together
    cfg(3, 32'h0400_0000, 32'h0, 32'h0, 8'd0, 1'b1, 1'b1);
    chk("oor_accepted_ready_low", 64'(cfg_ready), 64'd0);
    tick();
    chk("ready_back_high", 64'(cfg_ready), 64'd1);
    tick();
    chk("apply_sin0_a", s16(0), w16(0));
    chk("apply_sin1_a", s16(1), w16(0));
    tick();
    chk("apply_sin0_b", s16(0), w16(1608));
    chk("apply_sin1_b", s16(1), w16(-1608));
    chk("oor_ch2_sin", s16(2), w16(0));
    chk("oor_ch2_cos", c16(2), w16(32767));

    // Freeze: two increments after a clear, then en low
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    tick();
    tick();
    en = 1'b0;
    tick();
    chk("frz_valid_1", 64'(out_valid), 64'd1);
    tick();
    chk("frz_valid_2", 64'(out_valid), 64'd1);
    chk("frz_sin0_last", s16(0), w16(3212));
    tick();
    chk("frz_valid_3", 64'(out_valid), 64'd0);
    repeat (4) tick();
    chk("frz_hold_sin0", s16(0), w16(3212));
    chk("frz_hold_sin1", s16(1), w16(-3212));
    chk("frz_hold_valid", 64'(out_valid), 64'd0);
    en = 1'b1;
    tick();
    chk("resume_valid_1", 64'(out_valid), 64'd0);
    tick();
    chk("resume_valid_2", 64'(out_valid), 64'd0);
    chk("resume_hold_sin0", s16(0), w16(3212));
    tick();
    chk("resume_valid_3", 64'(out_valid), 64'd1);
    chk("resume_sin0", s16(0), w16(4808));

    // Up-sweep on ch0: reload every 17 enabled cycles
    cfg(0, 32'h0010_0000, 32'h0001_0000, 32'h0020_0000, 8'd0, 1'b1, 1'b0);
    chk("sweep_apply_wrap", 64'(sweep_wrap), 64'd0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("sweep_up_wrap", 64'(sweep_wrap), (k % 17 == 0) ? 64'd1 : 64'd0);
    end

    // Down-sweep with borrow on ch1: reloads every cycle
    cfg(1, 32'h0000_0010, 32'hFFFF_FFE0, 32'h0, 8'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sweep_down_wrap", 64'(sweep_wrap), 64'd2);
    end

    // Asynchronous reset mid-run
    rst_n = 1'b0;
    #1;
    chk("arst_sin", 64'(sin_out), 64'd0);
    chk("arst_cos", 64'(cos_out), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_wrap", 64'(sweep_wrap), 64'd0);
    chk("arst_ready", 64'(cfg_ready), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
